reg_file_16x16: RTL

//   Architectural register file for the 16-bit core: 16 x 16-bit GPRs built from
//   dff_16bit words, plus the 3-bit ALU flag register (Z,V,N) built from dff_3bit.

---
 rtl/reg_file_16x16.sv | 108 ++++++++++
 1 files changed

// File: rtl/reg_file_16x16.sv
// 16 x 16-bit GPR file with Z/V/N flag register, two combinational read ports, one write port.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.

module dff_16bit #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// Per-bit enables so each flag can be updated independently of the others.
module dff_3bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i_en,
  input  logic [2:0] i_d,
  output logic [2:0] o_q
);
  logic [2:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= (r_q & ~i_en) | (i_d & i_en);
  end

  assign o_q = r_q;
endmodule

module reg_file_16x16 #(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 16,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] src_reg1,
  input  logic [$clog2(NREGS)-1:0] src_reg2,
  output logic [DATA_W-1:0]        src_data1,
  output logic [DATA_W-1:0]        src_data2,
  input  logic                     write_reg,
  input  logic [$clog2(NREGS)-1:0] dst_reg,
  input  logic [DATA_W-1:0]        dst_data,
  input  logic [2:0]               flag_wen,
  input  logic [2:0]               flag_d,
  output logic [2:0]               flags
);
  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0]  w_wen;
  logic [DATA_W-1:0] w_q [NREGS];
  logic [2:0]        w_flags_q;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  // write_reg gates the decode first so an unknown dst_reg cannot enable a word
  for (genvar i = 0; i < NREGS; i++) begin : g_word
    assign w_wen[i] = write_reg && (dst_reg == AW'(i)) && (!ZERO_R0 || (i != 0));

    dff_16bit #(.W(DATA_W)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_wen[i]),
      .i_d   (dst_data),
      .o_q   (w_q[i])
    );
  end

  dff_3bit u_flags (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (flag_wen),
    .i_d   (flag_d),
    .o_q   (w_flags_q)
  );

  always_comb begin
    w_rd1 = w_q[src_reg1];
    w_rd2 = w_q[src_reg2];
`ifdef REGFILE_BYPASS_EN
    if (write_reg && (src_reg1 == dst_reg)) w_rd1 = dst_data;
    if (write_reg && (src_reg2 == dst_reg)) w_rd2 = dst_data;
`endif
    if (ZERO_R0 && (src_reg1 == '0)) w_rd1 = '0;
    if (ZERO_R0 && (src_reg2 == '0)) w_rd2 = '0;
  end

  assign src_data1 = w_rd1;
  assign src_data2 = w_rd2;

`ifdef REGFILE_BYPASS_EN
  assign flags = (w_flags_q & ~flag_wen) | (flag_d & flag_wen);
`else
  assign flags = w_flags_q;
`endif

endmodule
